// File: rtl/plab4_net_domain_merge_if.sv
// plab4_net_domain_merge_if: val/rdy message channel carrying a control word and a data payload.
//   val          : message valid, driven by master
//   rdy          : message accepted this cycle when val && rdy, driven by slave
//   msg_control  : p_msg_cnbits control word, driven by master
//   msg_data     : p_msg_dnbits payload, driven by master
interface plab4_net_domain_merge_if #(
    parameter int p_msg_cnbits = 41,
    parameter int p_msg_dnbits = 32
);
    logic                    val;
    logic                    rdy;
    logic [p_msg_cnbits-1:0] msg_control;
    logic [p_msg_dnbits-1:0] msg_data;
    modport master (output val, msg_control, msg_data, input rdy);
    modport slave  (input val, msg_control, msg_data, output rdy);
endinterface

// File: rtl/plab4_net_domain_merge.sv
// plab4_net_domain_merge: merges the domain-1 and domain-2 channels into one domain-tagged channel
// using per-domain FIFOs and a fixed time-division slot schedule.
//   clk        : clock, all state on posedge
//   reset      : asynchronous active-low reset; flushes both FIFOs and restarts the schedule
//   in_d1      : domain-1 input channel (slave); rdy = FIFO not full
//   in_d2      : domain-2 input channel (slave); rdy = FIFO not full
//   out        : merged output channel (master); carries the head of the granted FIFO
//   out_domain : 0 = domain 1, 1 = domain 2; tags the current output
// Optional feature: define PLAB4_NET_DOMAIN_MERGE_WORK_CONSERVING_EN to let an empty slot be
// borrowed by the other domain; the default build is strict TDM.
module plab4_net_domain_merge #(
    parameter int p_msg_cnbits  = 41,
    parameter int p_msg_dnbits  = 32,
    parameter int p_num_entries = 2,
    parameter int p_slot_len    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    plab4_net_domain_merge_if.slave          in_d1,
    plab4_net_domain_merge_if.slave          in_d2,
    plab4_net_domain_merge_if.master         out,
    output logic                             out_domain
);
    localparam int PW = p_num_entries > 1 ? $clog2(p_num_entries) : 1;
    localparam int CW = $clog2(p_num_entries + 1);
    localparam int SW = p_slot_len > 1 ? $clog2(p_slot_len) : 1;

    logic [p_msg_cnbits-1:0] ctrl_q [2][p_num_entries];
    logic [p_msg_dnbits-1:0] data_q [2][p_num_entries];
    logic [PW-1:0]           wr_ptr [2];
    logic [PW-1:0]           rd_ptr [2];
    logic [CW-1:0]           cnt    [2];
    logic [p_msg_cnbits-1:0] in_ctrl [2];
    logic [p_msg_dnbits-1:0] in_data [2];
    logic [1:0]              in_val, full, empty, enq, deq;
    logic [SW-1:0]           slot_cnt;
    logic                    cur_dom, gnt, wrap;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(p_num_entries - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_val     = {in_d2.val, in_d1.val};
    assign in_ctrl[0] = in_d1.msg_control;
    assign in_ctrl[1] = in_d2.msg_control;
    assign in_data[0] = in_d1.msg_data;
    assign in_data[1] = in_d2.msg_data;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            full[d]  = cnt[d] == CW'(p_num_entries);
            empty[d] = cnt[d] == '0;
        end
    end

    assign in_d1.rdy = !full[0];
    assign in_d2.rdy = !full[1];
    assign enq       = in_val & ~full;

    // The schedule free-runs; traffic never shifts slot boundaries.
    assign wrap = slot_cnt == SW'(p_slot_len - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            cur_dom  <= 1'b0;
        end else begin
            slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
            cur_dom  <= wrap ? !cur_dom : cur_dom;
        end
    end

`ifdef PLAB4_NET_DOMAIN_MERGE_WORK_CONSERVING_EN
    assign gnt = (empty[cur_dom] && !empty[!cur_dom]) ? !cur_dom : cur_dom;
`else
    assign gnt = cur_dom;
`endif

    // Payload is forced to zero when nothing is offered so idle outputs never leak stale entries.
    assign out.val         = !empty[gnt];
    assign out.msg_control = out.val ? ctrl_q[gnt][rd_ptr[gnt]] : '0;
    assign out.msg_data    = out.val ? data_q[gnt][rd_ptr[gnt]] : '0;
    assign out_domain      = gnt;
    assign deq             = (out.val && out.rdy) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                wr_ptr[d] <= '0;
                rd_ptr[d] <= '0;
                cnt[d]    <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                wr_ptr[d] <= enq[d] ? nxt(wr_ptr[d]) : wr_ptr[d];
                rd_ptr[d] <= deq[d] ? nxt(rd_ptr[d]) : rd_ptr[d];
                cnt[d]    <= cnt[d] + CW'(enq[d]) - CW'(deq[d]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (enq[d]) begin
                ctrl_q[d][wr_ptr[d]] <= in_ctrl[d];
                data_q[d][wr_ptr[d]] <= in_data[d];
            end
        end
    end
endmodule

// File: tb/tb_plab4_net_domain_merge.sv
// tb_plab4_net_domain_merge: directed self-checking bench for plab4_net_domain_merge.
module tb_plab4_net_domain_merge;
    logic clk;
    logic reset;
    logic out_domain;
    int   total = 0;
    int   bad   = 0;

    plab4_net_domain_merge_if #(.p_msg_cnbits(41), .p_msg_dnbits(32)) d1_if ();
    plab4_net_domain_merge_if #(.p_msg_cnbits(41), .p_msg_dnbits(32)) d2_if ();
    plab4_net_domain_merge_if #(.p_msg_cnbits(41), .p_msg_dnbits(32)) out_if ();

    plab4_net_domain_merge #(
        .p_msg_cnbits(41), .p_msg_dnbits(32), .p_num_entries(2), .p_slot_len(4)
    ) dut (
        .clk(clk), .reset(reset), .in_d1(d1_if.slave), .in_d2(d2_if.slave),
        .out(out_if.master), .out_domain(out_domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_d1(input logic v, input logic [40:0] c, input logic [31:0] d);
        d1_if.val = v;
        d1_if.msg_control = c;
        d1_if.msg_data = d;
    endtask

    task automatic put_d2(input logic v, input logic [40:0] c, input logic [31:0] d);
        d2_if.val = v;
        d2_if.msg_control = c;
        d2_if.msg_data = d;
    endtask

    // Leaves the bench just after reset release: this is cycle 0 of the schedule.
    task automatic do_reset();
        reset = 1'b0;
        put_d1(1'b0, '0, '0);
        put_d2(1'b0, '0, '0);
        out_if.rdy = 1'b0;
        step();
        reset = 1'b1;
    endtask

    logic        t4_val  [6] = '{1, 1, 0, 0, 1, 1};
    logic        t4_dom  [6] = '{0, 0, 0, 0, 1, 1};
    logic [31:0] t4_data [6] = '{32'h41, 32'h42, 32'h0, 32'h0, 32'h81, 32'h82};

    initial begin
        reset = 1'b0;
        put_d1(1'b0, '0, '0);
        put_d2(1'b0, '0, '0);
        out_if.rdy = 1'b0;
        step();
        chk("rst_out_val", out_if.val, 0);
        chk("rst_out_domain", out_domain, 0);
        chk("rst_out_ctrl", out_if.msg_control, 0);
        chk("rst_out_data", out_if.msg_data, 0);
        chk("rst_rdy_d1", d1_if.rdy, 1);
        chk("rst_rdy_d2", d2_if.rdy, 1);
        reset = 1'b1;

        // single domain-1 message, visible one cycle after enqueue
        put_d1(1'b1, 41'h0A5, 32'hDEADBEEF);
        out_if.rdy = 1'b1;
        chk("t1_c0_val", out_if.val, 0);
        step();
        put_d1(1'b0, '0, '0);
        chk("t1_c1_val", out_if.val, 1);
        chk("t1_c1_dom", out_domain, 0);
        chk("t1_c1_data", out_if.msg_data, 32'hDEADBEEF);
        chk("t1_c1_ctrl", out_if.msg_control, 41'h0A5);
        step();
        chk("t1_c2_val", out_if.val, 0);

        // domain-2 message waits for its slot
        do_reset();
        put_d2(1'b1, 41'h111, 32'h22222222);
        out_if.rdy = 1'b1;
        step();
        put_d2(1'b0, '0, '0);
`ifdef PLAB4_NET_DOMAIN_MERGE_WORK_CONSERVING_EN
        chk("wc_c1_val", out_if.val, 1);
        chk("wc_c1_dom", out_domain, 1);
        chk("wc_c1_data", out_if.msg_data, 32'h22222222);
`else
        for (int c = 1; c < 4; c++) begin
            chk("t2_wait_val", out_if.val, 0);
            step();
        end
        chk("t2_c4_val", out_if.val, 1);
        chk("t2_c4_dom", out_domain, 1);
        chk("t2_c4_data", out_if.msg_data, 32'h22222222);
        step();
        chk("t2_c5_val", out_if.val, 0);

        // fill domain 1 while stalled, third message held at the input
        do_reset();
        put_d1(1'b1, 41'h1, 32'hA0);
        step();
        chk("t3_c1_rdy", d1_if.rdy, 1);
        put_d1(1'b1, 41'h2, 32'hB0);
        step();
        chk("t3_c2_rdy", d1_if.rdy, 0);
        put_d1(1'b1, 41'h3, 32'hC0);
        step();
        chk("t3_c3_rdy", d1_if.rdy, 0);
        chk("t3_c3_val", out_if.val, 1);
        chk("t3_c3_data", out_if.msg_data, 32'hA0);
        out_if.rdy = 1'b1;
        step();
        chk("t3_c4_rdy", d1_if.rdy, 1);
        chk("t3_c4_dom", out_domain, 1);
        chk("t3_c4_val", out_if.val, 0);
        step();
        put_d1(1'b0, '0, '0);
        step();
        step();
        step();
        chk("t3_c8_val", out_if.val, 1);
        chk("t3_c8_dom", out_domain, 0);
        chk("t3_c8_data", out_if.msg_data, 32'hB0);
        step();
        chk("t3_c9_data", out_if.msg_data, 32'hC0);
        chk("t3_c9_ctrl", out_if.msg_control, 41'h3);
        step();
        chk("t3_c10_val", out_if.val, 0);

        // both FIFOs preloaded, drained across two slots
        do_reset();
        put_d1(1'b1, 41'h41, 32'h41);
        put_d2(1'b1, 41'h81, 32'h81);
        step();
        put_d1(1'b1, 41'h42, 32'h42);
        put_d2(1'b1, 41'h82, 32'h82);
        step();
        put_d1(1'b0, '0, '0);
        put_d2(1'b0, '0, '0);
        for (int c = 2; c < 8; c++) step();
        out_if.rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t4_val", out_if.val, t4_val[i]);
            chk("t4_dom", out_domain, t4_dom[i]);
            chk("t4_data", out_if.msg_data, t4_data[i]);
            step();
        end

        // head stalled in the last cycle of its slot reappears exactly once
        do_reset();
        step();
        step();
        put_d1(1'b1, 41'h55, 32'h55);
        step();
        put_d1(1'b0, '0, '0);
        chk("t5_c3_val", out_if.val, 1);
        chk("t5_c3_data", out_if.msg_data, 32'h55);
        step();
        chk("t5_c4_dom", out_domain, 1);
        chk("t5_c4_val", out_if.val, 0);
        out_if.rdy = 1'b1;
        for (int c = 4; c < 8; c++) step();
        chk("t5_c8_val", out_if.val, 1);
        chk("t5_c8_dom", out_domain, 0);
        chk("t5_c8_data", out_if.msg_data, 32'h55);
        step();
        chk("t5_c9_val", out_if.val, 0);

        // asynchronous reset mid-burst flushes FIFOs and restarts the schedule
        do_reset();
        put_d1(1'b1, 41'h61, 32'h61);
        put_d2(1'b1, 41'h91, 32'h91);
        step();
        put_d1(1'b1, 41'h62, 32'h62);
        put_d2(1'b0, '0, '0);
        step();
        put_d1(1'b0, '0, '0);
        step();
        chk("t6_pre_val", out_if.val, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_val", out_if.val, 0);
        chk("t6_rst_rdy_d1", d1_if.rdy, 1);
        chk("t6_rst_rdy_d2", d2_if.rdy, 1);
        chk("t6_rst_dom", out_domain, 0);
        step();
        reset = 1'b1;
        chk("t6_c0_dom", out_domain, 0);
        put_d2(1'b1, 41'h99, 32'h99);
        out_if.rdy = 1'b1;
        step();
        put_d2(1'b0, '0, '0);
        for (int c = 1; c < 4; c++) begin
            chk("t6_idle_val", out_if.val, 0);
            chk("t6_idle_dom", out_domain, 0);
            step();
        end
        chk("t6_c4_val", out_if.val, 1);
        chk("t6_c4_dom", out_domain, 1);
        chk("t6_c4_data", out_if.msg_data, 32'h99);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
